// File: rtl/dda_link_ctrl.sv
// UART command controller for the Lorenz DDA tile: decodes W/R/S/H/D commands,
// owns the parameter register file and DDA enable, and sends replies half-duplex.
//
// state        | meaning
// IDLE         | waiting for an opcode byte
// GET_ADDR     | waiting for the address byte of W/R
// GET_DATA     | waiting for the data byte of W
// EXEC         | apply command, load reply buffer (one cycle)
// TX_LOAD      | tx_start pulse for buffer[idx]
// TX_WAIT_BUSY | waiting for the UART to accept the byte
// TX_WAIT_IDLE | waiting for the UART to finish the byte
module dda_link_ctrl #(
    parameter int REG_SIZE = 14,
    parameter int OUT_SIZE = 6,
    parameter int TIMEOUT  = 120000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_error,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    input  logic                  tx_busy,
    input  logic [8*OUT_SIZE-1:0] state_in,
    output logic [8*REG_SIZE-1:0] params,
    output logic                  dda_en,
    output logic                  busy
);

    localparam int AW = $clog2(REG_SIZE);
    localparam int BW = $clog2(OUT_SIZE + 2);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_S = 8'h53;
    localparam logic [7:0] OP_H = 8'h48;
    localparam logic [7:0] OP_D = 8'h44;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
    localparam logic [7:0] HDR  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, EXEC, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_IDLE
    } state_t;

    state_t          state;
    logic [7:0]      opcode;
    logic [7:0]      addr;
    logic [7:0]      data;
    logic [TW-1:0]   tmo_cnt;
    logic [BW-1:0]   idx;
    logic [BW-1:0]   len;
    logic [BW-1:0]   idx_nxt;
    logic [7:0]      regs [REG_SIZE];
    logic [7:0]      rbuf [OUT_SIZE+1];
    logic            addr_ok;
    logic [AW-1:0]   addr_idx;
    logic [7:0]      exec_first;
    logic [BW-1:0]   exec_len;

    function automatic logic [7:0] reg_default(input int i);
        case (i)
            0:       return 8'hC0;
            2:       return 8'h14;
            3:       return 8'hCD;
            4:       return 8'h72;
            5:       return 8'h40;
            6:       return 8'h6A;
            8:       return 8'h55;
            9:       return 8'h55;
            10:      return 8'h73;
            12:      return 8'h04;
            default: return 8'h00;
        endcase
    endfunction

    for (genvar g = 0; g < REG_SIZE; g++) begin : g_params
        assign params[8*(REG_SIZE-g)-1 -: 8] = regs[g];
    end

    assign addr_ok  = int'(addr) < REG_SIZE;
    assign addr_idx = addr[AW-1:0];
    assign idx_nxt  = idx + 1'b1;
    assign busy     = (state != IDLE);

    always_comb begin
        exec_first = NAK;
        exec_len   = BW'(1);
        case (opcode)
            OP_W: exec_first = addr_ok ? ACK : NAK;
            OP_R: exec_first = addr_ok ? regs[addr_idx] : NAK;
            OP_S, OP_H: exec_first = ACK;
            OP_D: begin
                exec_first = HDR;
                exec_len   = BW'(OUT_SIZE + 1);
            end
            default: exec_first = NAK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opcode   <= '0;
            addr     <= '0;
            data     <= '0;
            tmo_cnt  <= '0;
            idx      <= '0;
            len      <= '0;
            tx_start <= 1'b0;
            tx_byte  <= '0;
            dda_en   <= 1'b1;
            for (int i = 0; i < REG_SIZE; i++) regs[i] <= reg_default(i);
            for (int i = 0; i <= OUT_SIZE; i++) rbuf[i] <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    // a byte that arrives together with a framing error is discarded
                    if (rx_valid && !rx_error) begin
                        opcode  <= rx_byte;
                        tmo_cnt <= '0;
                        state   <= (rx_byte == OP_W || rx_byte == OP_R) ? GET_ADDR : EXEC;
                    end
                end
                GET_ADDR: begin
                    if (rx_error) begin
                        state <= IDLE;
                    end else if (rx_valid) begin
                        addr    <= rx_byte;
                        tmo_cnt <= '0;
                        state   <= (opcode == OP_W) ? GET_DATA : EXEC;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GET_DATA: begin
                    if (rx_error) begin
                        state <= IDLE;
                    end else if (rx_valid) begin
                        data    <= rx_byte;
                        tmo_cnt <= '0;
                        state   <= EXEC;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    case (opcode)
                        OP_W: if (addr_ok) regs[addr_idx] <= data;
                        OP_S: dda_en <= 1'b1;
                        OP_H: dda_en <= 1'b0;
                        OP_D: for (int j = 0; j < OUT_SIZE; j++)
                                  rbuf[j+1] <= state_in[8*(OUT_SIZE-j)-1 -: 8];
                        default: ;
                    endcase
                    rbuf[0]  <= exec_first;
                    len      <= exec_len;
                    idx      <= '0;
                    tx_byte  <= exec_first;
                    tx_start <= 1'b1;
                    state    <= TX_LOAD;
                end
                TX_LOAD: state <= TX_WAIT_BUSY;
                TX_WAIT_BUSY: if (tx_busy) state <= TX_WAIT_IDLE;
                TX_WAIT_IDLE: begin
                    if (!tx_busy) begin
                        idx <= idx_nxt;
                        if (idx_nxt == len) begin
                            state <= IDLE;
                        end else begin
                            tx_byte  <= rbuf[idx_nxt];
                            tx_start <= 1'b1;
                            state    <= TX_LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
